// File: rtl/dff.sv
// Parameterised register stage: a chain of STAGES flops with synchronous
// active-high reset and a defined power-on value in every stage.
module dff #(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reject illegal parameterisations at elaboration time.
    if ((WIDTH < 32'd1) || (WIDTH > 32'd1024)) begin : g_bad_width
        $error("dff: WIDTH must be in 1..1024");
    end
    if ((STAGES < 32'd1) || (STAGES > 32'd64)) begin : g_bad_stages
        $error("dff: STAGES must be in 1..64");
    end

    // The declaration initialiser gives every stage RESET_VALUE at power-on,
    // so q is defined before the first clock edge or reset.
    logic [STAGES-1:0][WIDTH-1:0] stage_q = {STAGES{RESET_VALUE}};
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    // Next state of the chain: d enters stage 0, every other stage shifts by one.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = d;
        for (int i = 1; i < int'(STAGES); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Chain registers; reset wins over capture and flushes all in-flight data.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= {STAGES{RESET_VALUE}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: tb/tb_dff.sv
// Directed self-checking bench for dff: toggle, synchronous reset, reset
// priority, multi-stage latency, flush on reset and power-on value.
module tb_dff;

    logic       clk = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    // WIDTH=1, STAGES=1, RESET_VALUE=0
    logic       rst_t = 1'b0;
    logic       d_t   = 1'b0;
    logic       q_t;
    // WIDTH=1, STAGES=1, RESET_VALUE=1
    logic       rst_r1 = 1'b0;
    logic       d_r1   = 1'b0;
    logic       q_r1;
    // WIDTH=8, STAGES=3, RESET_VALUE=0
    logic       rst_m3 = 1'b0;
    logic [7:0] d_m3   = 8'h00;
    logic [7:0] q_m3;
    // WIDTH=8, STAGES=3, RESET_VALUE=A5
    logic       rst_fl = 1'b0;
    logic [7:0] d_fl   = 8'h00;
    logic [7:0] q_fl;
    // WIDTH=4, STAGES=1, RESET_VALUE=9
    logic       rst_po = 1'b0;
    logic [3:0] d_po   = 4'h0;
    logic [3:0] q_po;

    dff #(.WIDTH(1), .STAGES(1), .RESET_VALUE(1'b0)) u_tog (
        .clk(clk), .rst(rst_t), .d(d_t), .q(q_t));
    dff #(.WIDTH(1), .STAGES(1), .RESET_VALUE(1'b1)) u_rv1 (
        .clk(clk), .rst(rst_r1), .d(d_r1), .q(q_r1));
    dff #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'h00)) u_m3 (
        .clk(clk), .rst(rst_m3), .d(d_m3), .q(q_m3));
    dff #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hA5)) u_fl (
        .clk(clk), .rst(rst_fl), .d(d_fl), .q(q_fl));
    dff #(.WIDTH(4), .STAGES(1), .RESET_VALUE(4'h9)) u_po (
        .clk(clk), .rst(rst_po), .d(d_po), .q(q_po));

    // 10 ns clock, first rising edge at 5 ns.
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] m3_din [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h44};
    logic [7:0] m3_exp [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        // Power-on values, before any clock edge.
        #1;
        check_vec("poweron_w4", 32'(q_po), 32'h9);
        check_vec("poweron_tog", 32'(q_t), 32'h0);
        check_vec("poweron_rv1", 32'(q_r1), 32'h1);
        check_vec("poweron_fl", 32'(q_fl), 32'hA5);

        // Toggle: d changes on falling edges, q follows on the next rising edge.
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            d_t = 1'(k % 2);
            #1;
            check_vec("toggle_hold", 32'(q_t), 32'((k - 1) % 2));
            edge_sample();
            check_vec("toggle", 32'(q_t), 32'(k % 2));
        end

        // Synchronous reset raised mid-cycle.
        @(negedge clk);
        d_t = 1'b1;
        edge_sample();
        check_vec("srst_pre", 32'(q_t), 32'h1);
        @(negedge clk);
        rst_t = 1'b1;
        #1;
        check_vec("srst_between", 32'(q_t), 32'h1);
        edge_sample();
        check_vec("srst_edge", 32'(q_t), 32'h0);
        edge_sample();
        check_vec("srst_held", 32'(q_t), 32'h0);
        @(negedge clk);
        rst_t = 1'b0;
        #1;
        check_vec("srst_release_between", 32'(q_t), 32'h0);
        edge_sample();
        check_vec("srst_release", 32'(q_t), 32'h1);

        // Reset priority, RESET_VALUE=0 with d=1 and RESET_VALUE=1 with d=0.
        @(negedge clk);
        rst_t = 1'b1;
        d_t   = 1'b1;
        d_r1  = 1'b0;
        edge_sample();
        check_vec("prio_rv0", 32'(q_t), 32'h0);
        check_vec("rv1_pre", 32'(q_r1), 32'h0);
        @(negedge clk);
        rst_t  = 1'b0;
        rst_r1 = 1'b1;
        edge_sample();
        check_vec("prio_rv1", 32'(q_r1), 32'h1);
        @(negedge clk);
        rst_r1 = 1'b0;
        edge_sample();
        check_vec("rv1_release", 32'(q_r1), 32'h0);

        // Three-stage latency.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d_m3 = m3_din[i];
            edge_sample();
            check_vec("latency3", 32'(q_m3), 32'(m3_exp[i]));
        end

        // Flush on reset with RESET_VALUE=A5.
        @(negedge clk); d_fl = 8'h01;
        edge_sample();
        @(negedge clk); d_fl = 8'h02;
        edge_sample();
        @(negedge clk); d_fl = 8'h03;
        edge_sample();
        check_vec("flush_pre", 32'(q_fl), 32'h01);
        @(negedge clk);
        rst_fl = 1'b1;
        d_fl   = 8'hFF;
        edge_sample();
        check_vec("flush_rst", 32'(q_fl), 32'hA5);
        @(negedge clk);
        rst_fl = 1'b0;
        d_fl   = 8'h7E;
        edge_sample();
        check_vec("flush_p1", 32'(q_fl), 32'hA5);
        edge_sample();
        check_vec("flush_p2", 32'(q_fl), 32'hA5);
        edge_sample();
        check_vec("flush_p3", 32'(q_fl), 32'h7E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
